alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters (A and B) using a valid/ready handshake on each request port and on a single shared response channel.
- Registers the granted operands, runs one ALU evaluation and holds a registered result until the consumer accepts it.
- Sits between the issue logic of two datapath clients and the ALU; also counts completed operations.

---
 rtl/alu_arbiter_pkg.sv | 14 +
 rtl/alu_arbiter_alu.sv | 19 +
 rtl/alu_arbiter.sv | 79 +++++++
 tb/tb_alu_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, illegal-op check, FSM encoding and requester IDs shared by the arbiter and its ALU
package alu_arbiter_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_GT  = 3'b111;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  function automatic logic is_illegal(input logic [2:0] op);
    return !(op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB || op == OP_GT);
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU (op1, op2, aluop -> result); illegal codes give 0
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       aluop,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = aluop == OP_AND ? op1 & op2 :
             aluop == OP_OR  ? op1 | op2 :
             aluop == OP_ADD ? op1 + op2 :
             aluop == OP_SUB ? op1 - op2 :
             aluop == OP_GT  ? {{(WIDTH-1){1'b0}}, op1 > op2} : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between requesters A/B (valid/ready in, rsp valid/ready out, ops_done counter)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] a_op2,
  input  logic [2:0]       a_aluop,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_op1,
  input  logic [WIDTH-1:0] b_op2,
  input  logic [2:0]       b_aluop,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);
  state_t state, state_nx;
  logic [WIDTH-1:0] op1_q, op2_q, alu_res;
  logic [2:0] aluop_q;
  logic owner_q, last_grant, idle;
  assign idle = state == IDLE && rst_n;
  always_comb begin
    a_ready = idle && a_valid && (!b_valid || last_grant == ID_B);
    b_ready = idle && b_valid && (!a_valid || last_grant == ID_A);
    state_nx = state == IDLE ? ((a_ready || b_ready) ? EXEC : IDLE) :
               state == EXEC ? RESP :
               state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op1(op1_q),
    .op2(op2_q),
    .aluop(aluop_q),
    .result(alu_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= ID_B;
      op1_q <= '0;
      op2_q <= '0;
      aluop_q <= '0;
      owner_q <= ID_A;
      rsp_valid <= 1'b0;
      rsp_id <= ID_A;
      rsp_result <= '0;
      rsp_err <= 1'b0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (a_ready || b_ready) begin
        op1_q <= a_ready ? a_op1 : b_op1;
        op2_q <= a_ready ? a_op2 : b_op2;
        aluop_q <= a_ready ? a_aluop : b_aluop;
        owner_q <= a_ready ? ID_A : ID_B;
      end
      if (state == EXEC) begin
        rsp_result <= is_illegal(aluop_q) ? '0 : alu_res;
        rsp_err <= is_illegal(aluop_q);
        rsp_id <= owner_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        last_grant <= owner_q;
        ops_done <= ops_done + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 0, b_valid = 0, rsp_ready = 1;
  logic a_ready, b_ready, rsp_valid, rsp_id, rsp_err;
  logic [31:0] a_op1 = 0, a_op2 = 0, b_op1 = 0, b_op2 = 0, rsp_result;
  logic [2:0] a_aluop = 0, b_aluop = 0;
  logic [15:0] ops_done;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_aluop(a_aluop),
    .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_aluop(b_aluop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .ops_done(ops_done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_a(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    a_valid = v; a_op1 = x; a_op2 = y; a_aluop = op;
  endtask
  task automatic set_b(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    b_valid = v; b_op1 = x; b_op2 = y; b_aluop = op;
  endtask
  // called just after a negedge in IDLE with requests driven and rsp_ready=1; ends at the next IDLE negedge
  task automatic cycle_op(input string tag, input logic ea, input logic eb, input logic eid,
                          input logic [31:0] eres, input logic eerr);
    #1;
    check({tag, " a_ready"}, a_ready, ea);
    check({tag, " b_ready"}, b_ready, eb);
    @(negedge clk);
    check({tag, " exec rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " rsp_id"}, rsp_id, eid);
    check({tag, " rsp_result"}, rsp_result, eres);
    check({tag, " rsp_err"}, rsp_err, eerr);
    @(negedge clk);
    check({tag, " done rsp_valid"}, rsp_valid, 0);
  endtask
  initial begin
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset ops_done", ops_done, 0);
    check("reset a_ready", a_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_a(1, 5, 3, 3'b010);
    cycle_op("add", 1, 0, 0, 8, 0);
    set_a(0, 0, 0, 0);
    check("add ops_done", ops_done, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_a(1, 32'hF0, 32'h3C, 3'b000);
    set_b(1, 10, 12, 3'b110);
    cycle_op("rr1 A", 1, 0, 0, 32'h30, 0);
    cycle_op("rr2 B", 0, 1, 1, 32'hFFFFFFFE, 0);
    cycle_op("rr3 A", 1, 0, 0, 32'h30, 0);
    cycle_op("rr4 B", 0, 1, 1, 32'hFFFFFFFE, 0);
    check("rr ops_done", ops_done, 4);
    set_a(0, 0, 0, 0);
    set_b(1, 7, 7, 3'b101);
    cycle_op("illegal", 0, 1, 1, 0, 1);
    check("illegal ops_done", ops_done, 5);
    set_a(1, 9, 4, 3'b111);
    set_b(1, 1, 2, 3'b010);
    rsp_ready = 0;
    #1;
    check("bp a_ready", a_ready, 1);
    check("bp b_ready", b_ready, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_result", rsp_result, 1);
      check("bp rsp_id", rsp_id, 0);
      check("bp a_ready held", a_ready, 0);
      check("bp b_ready held", b_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    check("bp no grant in handshake cycle", b_ready, 0);
    @(negedge clk);
    set_a(0, 0, 0, 0);
    cycle_op("bp next B", 0, 1, 1, 3, 0);
    set_b(0, 0, 0, 0);
    check("bp ops_done", ops_done, 7);
    set_a(1, 1, 1, 3'b010);
    #1;
    check("rst a_ready", a_ready, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst mid a_ready", a_ready, 0);
    check("rst mid ops_done", ops_done, 0);
    check("rst mid rsp_result", rsp_result, 0);
    check("rst mid rsp_id", rsp_id, 0);
    check("rst mid rsp_err", rsp_err, 0);
    repeat (3) @(negedge clk);
    check("rst mid rsp_valid", rsp_valid, 0);
    set_a(0, 0, 0, 0);
    rst_n = 1;
    @(negedge clk);
    check("post rst rsp_valid", rsp_valid, 0);
    set_b(1, 20, 22, 3'b010);
    cycle_op("post rst B", 0, 1, 1, 42, 0);
    set_b(0, 0, 0, 0);
    check("post rst ops_done", ops_done, 1);
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    #1;
    check("preload ops_done", ops_done, 32'hFFFF);
    @(negedge clk);
    set_a(1, 32'hFFFFFFFF, 1, 3'b010);
    cycle_op("wrap", 1, 0, 0, 0, 0);
    set_a(0, 0, 0, 0);
    check("wrap ops_done", ops_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
